// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port, synchronous-read block RAM between two
// requesters; registers all RAM-side control and returns tagged read-valid strobes.
module ram_port_arbiter #(
  parameter int blockLength     = 32,
  parameter int memDepth        = 1024,
  parameter int addressBitWidth = 10
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req0,
  input  logic                       we0,
  input  logic [addressBitWidth-1:0] addr0,
  input  logic [blockLength-1:0]     wdata0,
  output logic                       gnt0,
  output logic                       rvalid0,
  input  logic                       req1,
  input  logic                       we1,
  input  logic [addressBitWidth-1:0] addr1,
  input  logic [blockLength-1:0]     wdata1,
  output logic                       gnt1,
  output logic                       rvalid1,
  output logic [blockLength-1:0]     rdata,
  output logic [addressBitWidth-1:0] ram_address,
  output logic                       ram_we,
  output logic [blockLength-1:0]     ram_dataIn,
  input  logic [blockLength-1:0]     ram_dataOut
);

  // A depth that disagrees with the address width leaves part of the RAM unreachable.
  if (memDepth != (1 << addressBitWidth)) begin : g_depth_mismatch
    logic depth_mismatch;
    assign depth_mismatch = 1'b1;
  end

  logic                       last_winner;
  logic                       rd_pend_p0;
  logic                       rd_tag_p0;
  logic                       elig0;
  logic                       elig1;
  logic                       win0;
  logic                       win1;
  logic                       sel_we;
  logic [addressBitWidth-1:0] sel_addr;
  logic [blockLength-1:0]     sel_wdata;

  // A requester granted this cycle is masked so its held req is not issued twice.
  always_comb begin
    elig0 = req0 & ~gnt0;
    elig1 = req1 & ~gnt1;
    win0  = elig0 & (~elig1 | last_winner);
    win1  = elig1 & (~elig0 | ~last_winner);
  end

  always_comb begin
    sel_we    = we0;
    sel_addr  = addr0;
    sel_wdata = wdata0;
    if (win1) begin
      sel_we    = we1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end
  end

  // Stage p0: arbitration result, grant pulses and RAM command.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      ram_we      <= 1'b0;
      last_winner <= 1'b1;
      rd_pend_p0  <= 1'b0;
      rd_tag_p0   <= 1'b0;
    end else begin
      gnt0       <= win0;
      gnt1       <= win1;
      ram_we     <= (win0 | win1) & sel_we;
      rd_pend_p0 <= (win0 | win1) & ~sel_we;
      if (win0 | win1) begin
        last_winner <= win1;
        rd_tag_p0   <= win1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ram_address <= '0;
      ram_dataIn  <= '0;
    end else if (win0 | win1) begin
      ram_address <= sel_addr;
      ram_dataIn  <= sel_wdata;
    end
  end

  // Stage p1: the RAM registers read data on this same edge, so rvalid lines up with rdata.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= rd_pend_p0 & ~rd_tag_p0;
      rvalid1 <= rd_pend_p0 & rd_tag_p0;
    end
  end

  assign rdata = ram_dataOut;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural synchronous-read RAM attached.
module tb_ram_port_arbiter;
  localparam int BL = 32;
  localparam int AW = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [BL-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [BL-1:0] rdata;
  logic [AW-1:0] ram_address;
  logic          ram_we;
  logic [BL-1:0] ram_dataIn;
  logic [BL-1:0] ram_dataOut;

  int n_cmp = 0;
  int n_bad = 0;
  logic [BL-1:0] gold [0:15];

  always #5 clock = ~clock;

  ram_port_arbiter #(.blockLength(BL), .memDepth(1024), .addressBitWidth(AW)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .ram_address(ram_address), .ram_we(ram_we), .ram_dataIn(ram_dataIn),
    .ram_dataOut(ram_dataOut)
  );

  // Unwritten words read back as 0xA0000000 | address.
  bit [BL-1:0] mem     [0:1023];
  bit          written [0:1023];
  always @(posedge clock) begin
    ram_dataOut <= written[ram_address] ? mem[ram_address] : (32'hA000_0000 | BL'(ram_address));
    if (ram_we) begin
      mem[ram_address]     <= ram_dataIn;
      written[ram_address] <= 1'b1;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    #3;
    n_cmp++; if (gnt0 !== 1'b0) begin n_bad++; $display("FAIL rst_gnt0: got %b want 0", gnt0); end
    n_cmp++; if (gnt1 !== 1'b0) begin n_bad++; $display("FAIL rst_gnt1: got %b want 0", gnt1); end
    n_cmp++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid: got %b%b want 00", rvalid0, rvalid1); end
    n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", ram_we); end
    n_cmp++; if (ram_address !== '0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", ram_address); end
    n_cmp++; if (ram_dataIn !== '0) begin n_bad++; $display("FAIL rst_din: got %h want 0", ram_dataIn); end
    step();
    reset = 1'b0;
    step();
  endtask

  // R0 read of addr 5 is granted, then reset lands before the RAM edge.
  task automatic test_reset_mid_read();
    req0 = 1; we0 = 0; addr0 = 10'd5;
    step();
    n_cmp++; if (gnt0 !== 1'b1 || ram_address !== 10'd5) begin n_bad++; $display("FAIL mid_gnt: got gnt0=%b addr=%h want 1/005", gnt0, ram_address); end
    req0 = 0;
    reset = 1'b1;
    #2;
    n_cmp++; if (gnt0 !== 1'b0 || ram_we !== 1'b0 || ram_address !== '0 || ram_dataIn !== '0) begin
      n_bad++; $display("FAIL mid_rst_outputs: got gnt0=%b we=%b addr=%h din=%h want 0", gnt0, ram_we, ram_address, ram_dataIn);
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin n_bad++; $display("FAIL mid_no_rvalid[%0d]: got %b%b want 00", c, rvalid0, rvalid1); end
    end
  endtask

  task automatic test_write_read();
    req0 = 1; we0 = 1; addr0 = 10'd3; wdata0 = 32'hDEADBEEF;
    step();
    n_cmp++; if (gnt0 !== 1'b1 || ram_we !== 1'b1) begin n_bad++; $display("FAIL wr_gnt: got gnt0=%b we=%b want 1/1", gnt0, ram_we); end
    n_cmp++; if (ram_address !== 10'd3 || ram_dataIn !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_cmd: got %h/%h want 003/deadbeef", ram_address, ram_dataIn); end
    gold[3] = 32'hDEADBEEF;
    we0 = 0; wdata0 = '0;
    step();
    n_cmp++; if (gnt0 !== 1'b0 || ram_we !== 1'b0 || rvalid0 !== 1'b0) begin n_bad++; $display("FAIL wr_gap: got gnt0=%b we=%b rv0=%b want 000", gnt0, ram_we, rvalid0); end
    step();
    n_cmp++; if (gnt0 !== 1'b1 || ram_we !== 1'b0 || ram_address !== 10'd3) begin n_bad++; $display("FAIL rd_gnt: got gnt0=%b we=%b addr=%h want 1/0/003", gnt0, ram_we, ram_address); end
    req0 = 0;
    step();
    n_cmp++; if (rvalid0 !== 1'b1 || rdata !== gold[3]) begin n_bad++; $display("FAIL rd_data: got rv0=%b rdata=%h want 1/%h", rvalid0, rdata, gold[3]); end
    n_cmp++; if (gnt0 !== 1'b0 || rvalid1 !== 1'b0) begin n_bad++; $display("FAIL rd_quiet: got gnt0=%b rv1=%b want 0/0", gnt0, rvalid1); end
    step();
  endtask

  task automatic test_simultaneous();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    step();
    req0 = 1; we0 = 0; addr0 = 10'd1;
    req1 = 1; we1 = 0; addr1 = 10'd2;
    step();
    n_cmp++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_bad++; $display("FAIL sim_first: got gnt=%b%b want 10 (gnt0,gnt1)", gnt0, gnt1); end
    req0 = 0;
    step();
    n_cmp++; if (gnt0 !== 1'b0 || gnt1 !== 1'b1 || ram_address !== 10'd2) begin n_bad++; $display("FAIL sim_second: got gnt=%b%b addr=%h want 01/002", gnt0, gnt1, ram_address); end
    n_cmp++; if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata !== gold[1]) begin n_bad++; $display("FAIL sim_rv0: got rv=%b%b rdata=%h want 10/%h", rvalid0, rvalid1, rdata, gold[1]); end
    req1 = 0;
    step();
    n_cmp++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b1 || rdata !== gold[2]) begin n_bad++; $display("FAIL sim_rv1: got rv=%b%b rdata=%h want 01/%h", rvalid0, rvalid1, rdata, gold[2]); end
    step();
  endtask

  task automatic test_saturation();
    int grants = 0;
    logic p0 = 1'b0;
    logic p1 = 1'b0;
    req0 = 1; we0 = 0; addr0 = 10'd10;
    req1 = 1; we1 = 0; addr1 = 10'd11;
    for (int i = 0; i < 20; i++) begin
      step();
      grants += int'(gnt0) + int'(gnt1);
      n_cmp++; if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1)) begin n_bad++; $display("FAIL sat_gnt[%0d]: got %b%b want %b%b", i, gnt0, gnt1, (i % 2 == 0), (i % 2 == 1)); end
      n_cmp++; if ((p0 && gnt0) || (p1 && gnt1)) begin n_bad++; $display("FAIL sat_b2b[%0d]: got repeat gnt=%b%b want none", i, gnt0, gnt1); end
      if (i > 0) begin
        n_cmp++; if (rvalid0 !== (i % 2 == 1) || rvalid1 !== (i % 2 == 0) || rdata !== gold[(i % 2 == 1) ? 10 : 11]) begin
          n_bad++; $display("FAIL sat_rv[%0d]: got rv=%b%b rdata=%h want %b%b/%h", i, rvalid0, rvalid1, rdata, (i % 2 == 1), (i % 2 == 0), gold[(i % 2 == 1) ? 10 : 11]);
        end
      end
      p0 = gnt0; p1 = gnt1;
    end
    req0 = 0; req1 = 0;
    step();
    n_cmp++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || rvalid1 !== 1'b1 || rvalid0 !== 1'b0) begin n_bad++; $display("FAIL sat_drain: got gnt=%b%b rv=%b%b want 00/01", gnt0, gnt1, rvalid0, rvalid1); end
    n_cmp++; if (grants !== 20) begin n_bad++; $display("FAIL sat_count: got %0d want 20", grants); end
    step();
  endtask

  task automatic test_streaming();
    int nxt = 0;
    req1 = 1; we1 = 0; addr1 = '0;
    for (int c = 0; c <= 16; c++) begin
      step();
      n_cmp++; if (gnt1 !== (c % 2 == 0 && c <= 14) || gnt0 !== 1'b0) begin n_bad++; $display("FAIL str_gnt[%0d]: got gnt=%b%b want 0%b", c, gnt0, gnt1, (c % 2 == 0 && c <= 14)); end
      n_cmp++; if (rvalid1 !== (c % 2 == 1) || rvalid0 !== 1'b0) begin n_bad++; $display("FAIL str_rv[%0d]: got rv=%b%b want 0%b", c, rvalid0, rvalid1, (c % 2 == 1)); end
      if (c % 2 == 1) begin
        n_cmp++; if (rdata !== gold[(c - 1) / 2]) begin n_bad++; $display("FAIL str_data[%0d]: got %h want %h", c, rdata, gold[(c - 1) / 2]); end
      end
      if (gnt1) begin
        nxt++;
        addr1 = AW'(nxt);
        if (nxt == 8) req1 = 0;
      end
    end
  endtask

  task automatic test_mixed();
    req0 = 1; we0 = 1; addr0 = 10'd9; wdata0 = 32'h11;
    req1 = 1; we1 = 0; addr1 = 10'd9;
    step();
    n_cmp++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || ram_we !== 1'b1) begin n_bad++; $display("FAIL mix_first: got gnt=%b%b we=%b want 10/1", gnt0, gnt1, ram_we); end
    gold[9] = 32'h11;
    req0 = 0; we0 = 0;
    step();
    n_cmp++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || ram_we !== 1'b0 || ram_address !== 10'd9) begin n_bad++; $display("FAIL mix_second: got gnt=%b%b we=%b addr=%h want 01/0/009", gnt0, gnt1, ram_we, ram_address); end
    req1 = 0;
    step();
    n_cmp++; if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata !== gold[9]) begin n_bad++; $display("FAIL mix_data: got rv=%b%b rdata=%h want 01/%h", rvalid0, rvalid1, rdata, gold[9]); end
    step();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) gold[i] = 32'hA000_0000 | i;
    test_reset();
    test_reset_mid_read();
    test_write_read();
    test_simultaneous();
    test_saturation();
    test_streaming();
    test_mixed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
